uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, giving the number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter SB_TICK, default 16, giving the stop-bit length in s_tick pulses (16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits).
REQ-003 SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port s_tick, input, 1 bit: 16x-oversample enable from the baud rate generator, a one-clk pulse.
REQ-006 SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port dout, output, DBIT bits: last received data word, LSB received first.
REQ-008 SHALL have port rx_done_tick, output, 1 bit: one-clk pulse when a frame completes.
REQ-009 SHALL have port frame_err, output, 1 bit: valid only while rx_done_tick=1; set when the stop bit sampled low.
REQ-010 SHALL have port parity_err, output, 1 bit: valid only while rx_done_tick=1; see Configuration.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (rx_s) before any use; each stage resets to 1.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with a 4-bit tick counter s and a bit counter n of width clog2(DBIT).
REQ-013 SHALL, in IDLE with rx_s=0, go to START with s=0 on the next clk, without waiting for s_tick.
REQ-014 SHALL advance s only on clk edges where s_tick=1 in START, DATA, PARITY and STOP.
REQ-015 SHALL, in START when s=7 and s_tick=1, go to DATA with s=0 and n=0 if rx_s=0; if rx_s=1 (false start/glitch), return to IDLE with no done pulse.
REQ-016 SHALL, in DATA when s=15 and s_tick=1, shift rx_s into the MSB of the shift register (right shift) and clear s; when n=DBIT-1, exit to PARITY (macro defined) or STOP, otherwise increment n.
REQ-017 SHALL, in PARITY when s=15 and s_tick=1, capture rx_s as the parity bit, go to STOP, and clear s.
REQ-018 SHALL, in STOP when s=SB_TICK-1 and s_tick=1, return to IDLE and, in that same clk, update dout from the shift register and assert rx_done_tick for exactly one clk.
REQ-019 SHALL set frame_err=~rx_s, sampled at the REQ-018 clk.
REQ-020 SHALL hold dout stable between done pulses; frame_err and parity_err are 0 when rx_done_tick=0.
REQ-021 SHALL ignore rx activity outside IDLE; a line held low through STOP yields a frame_err=1 frame, then a new START from IDLE.
REQ-022 SHALL keep internal state unchanged on cycles where s_tick=0; s never exceeds 15 (STOP uses a counter wide enough for SB_TICK-1).

Reset
REQ-023 SHALL, on Reset=1 at any time including mid-frame, force state=IDLE, s=0, n=0, shift register=0, dout=0, rx_done_tick=0, frame_err=0, parity_err=0, synchronizer=1.
REQ-024 SHALL start a new frame only on a fresh falling edge of rx_s after Reset deasserts.

Configuration
REQ-025 SHALL, when macro UART_RX_PARITY_EN is defined, include the PARITY state and set parity_err=1 at the done pulse when XOR(data bits, parity bit)=1 (even parity).
REQ-026 SHALL, when UART_RX_PARITY_EN is undefined, go directly DATA->STOP and tie parity_err to 0 while keeping the port present.

Verification
REQ-027 SHALL cover a single frame: s_tick every 4 clk, DBIT=8, send 0xA5 with a good stop bit -> one rx_done_tick, dout=0xA5, frame_err=0.
REQ-028 SHALL cover a glitch: rx low for 3 s_ticks then high -> no rx_done_tick, FSM back in IDLE, dout unchanged.
REQ-029 SHALL cover a frame error: send 0x3C with the stop bit driven 0 -> rx_done_tick with dout=0x3C, frame_err=1.
REQ-030 SHALL cover mid-frame reset: assert Reset during bit 4 of 0xFF, release, then send 0x12 -> exactly one done pulse, dout=0x12.
REQ-031 SHALL cover parity with UART_RX_PARITY_EN defined: send 0x07 with parity 1 -> parity_err=0; send 0x07 with parity 0 -> parity_err=1.
REQ-032 SHALL cover back-to-back frames: 0x55 then 0xAA with no idle gap, SB_TICK=16 -> two done pulses, dout=0x55 then 0xAA.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, DBIT data bits LSB first, SB_TICK-tick stop bit.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int unsigned CW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam logic [NW-1:0] NLast  = NW'(DBIT - 1);
  localparam logic [CW-1:0] SbLast = CW'(SB_TICK - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [CW-1:0]   sc_q, sc_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic            p_q, p_d;
  logic            perr_q, perr_d;
`endif

  // State register plus datapath registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      sc_q      <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_q       <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      sc_q      <= sc_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      p_q       <= p_d;
      perr_q    <= perr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sc_d    = sc_q;
    b_d     = b_q;
`ifdef UART_RX_PARITY_EN
    p_d     = p_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == 4'd7) begin
            s_d = '0;
            n_d = '0;
            // Line back high at mid start bit: treat as a glitch
            state_d = rx_s_q ? StIdle : StData;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == NLast) begin
              sc_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            p_d     = rx_s_q;
            s_d     = '0;
            sc_d    = '0;
            state_d = StStop;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
`endif
      StStop: begin
        if (s_tick) begin
          if (sc_q == SbLast) begin
            sc_d    = '0;
            state_d = StIdle;
          end else begin
            sc_d = sc_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: results are registered so they line up with the done pulse
  always_comb begin
    done_d = (state_q == StStop) && s_tick && (sc_q == SbLast);
    dout_d = done_d ? b_q : dout_q;
    ferr_d = done_d & ~rx_s_q;
`ifdef UART_RX_PARITY_EN
    perr_d = done_d & ((^b_q) ^ p_q);
`endif
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 64 clk per bit (s_tick every 4 clk), DBIT=8, SB_TICK=16.
module tb_uart_rx;

  logic       clk;
  logic       Reset;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int stray    = 0;
  logic last_ferr = 1'b0;
  logic last_perr = 1'b0;
  logic last_par  = 1'b0;

  uart_rx #(
    .DBIT   (8),
    .SB_TICK(16)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .s_tick      (s_tick),
    .rx          (rx),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int div;
    div    = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      div    = (div + 1) % 4;
      s_tick = (div == 0);
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt  <= done_cnt + 1;
      last_ferr <= frame_err;
      last_perr <= parity_err;
    end else if (frame_err || parity_err) begin
      stray <= stray + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a full frame; a low stop bit is held only until the done pulse appears.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    int c0;
    last_par = par;
    rx = 1'b0;
    wait_clk(64);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      wait_clk(64);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    wait_clk(64);
`endif
    rx = stop;
    if (stop) begin
      wait_clk(64);
    end else begin
      c0 = done_cnt;
      for (int i = 0; i < 128 && done_cnt == c0; i++) @(negedge clk);
      rx = 1'b1;
    end
  endtask

  initial begin
    int c;
    Reset = 1'b1;
    rx    = 1'b1;
    wait_clk(3);
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_done", 32'(rx_done_tick), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    check_eq("rst_perr", 32'(parity_err), 32'h0);
    Reset = 1'b0;
    wait_clk(20);

    // Single good frame; even parity bit for 0xA5 is 0
    send_frame(8'hA5, 1'b0, 1'b1);
    check_eq("a5_count", 32'(done_cnt), 32'd1);
    check_eq("a5_dout", 32'(dout), 32'hA5);
    check_eq("a5_ferr", 32'(last_ferr), 32'h0);
    check_eq("a5_perr", 32'(last_perr), 32'h0);

    // Start-bit glitch of 3 ticks
    rx = 1'b0;
    wait_clk(12);
    rx = 1'b1;
    wait_clk(200);
    check_eq("glitch_count", 32'(done_cnt), 32'd1);
    check_eq("glitch_dout", 32'(dout), 32'hA5);

    // Low stop bit; parity for 0x3C is 0
    send_frame(8'h3C, 1'b0, 1'b0);
    check_eq("ferr_count", 32'(done_cnt), 32'd2);
    check_eq("ferr_dout", 32'(dout), 32'h3C);
    check_eq("ferr_flag", 32'(last_ferr), 32'h1);
    wait_clk(300);
    check_eq("ferr_idle_count", 32'(done_cnt), 32'd2);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    check_eq("par_ok_dout", 32'(dout), 32'h07);
    check_eq("par_ok_perr", 32'(last_perr), 32'h0);
    send_frame(8'h07, 1'b0, 1'b1);
    check_eq("par_bad_perr", 32'(last_perr), 32'h1);
    check_eq("par_bad_ferr", 32'(last_ferr), 32'h0);
    wait_clk(20);
`endif

    // Back-to-back frames, no idle gap between them
    c = done_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    check_eq("b2b_55_count", 32'(done_cnt - c), 32'd1);
    check_eq("b2b_55_dout", 32'(dout), 32'h55);
    check_eq("b2b_55_ferr", 32'(last_ferr), 32'h0);
    send_frame(8'hAA, 1'b0, 1'b1);
    check_eq("b2b_aa_count", 32'(done_cnt - c), 32'd2);
    check_eq("b2b_aa_dout", 32'(dout), 32'hAA);
    check_eq("b2b_aa_ferr", 32'(last_ferr), 32'h0);
    wait_clk(20);

    // Reset in the middle of data bit 4 of 0xFF
    c = done_cnt;
    rx = 1'b0;
    wait_clk(64);
    rx = 1'b1;
    wait_clk(4 * 64 + 32);
    Reset = 1'b1;
    wait_clk(3);
    check_eq("mid_rst_dout", 32'(dout), 32'h0);
    check_eq("mid_rst_done", 32'(rx_done_tick), 32'h0);
    Reset = 1'b0;
    wait_clk(200);
    check_eq("mid_rst_no_done", 32'(done_cnt - c), 32'd0);
    send_frame(8'h12, 1'b0, 1'b1);
    check_eq("mid_rst_count", 32'(done_cnt - c), 32'd1);
    check_eq("mid_rst_dout12", 32'(dout), 32'h12);
    wait_clk(100);
    check_eq("mid_rst_final_count", 32'(done_cnt - c), 32'd1);

    check_eq("stray_err_flags", 32'(stray), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
